// File: rtl/acorn_phase_ctrl_if.sv
// Host-side bundle for acorn_phase_ctrl: job setup, the serial AD/plaintext
// handshake and the per-step controls that feed the state-update datapath.
interface acorn_phase_ctrl_if #(
  parameter int LEN_W = 16
);
  logic             start;
  logic [127:0]     key_in;
  logic [127:0]     iv_in;
  logic [LEN_W-1:0] ad_len;
  logic [LEN_W-1:0] msg_len;
  logic             din_bit;
  logic             din_valid;
  logic             din_ready;
  logic             step_en;
  logic             m_bit;
  logic             ca;
  logic             cb;
  logic             ks_valid;
  logic             tag_valid;
  logic [2:0]       phase;
  logic             busy;
  logic             done;

  modport master (
    output start, key_in, iv_in, ad_len, msg_len, din_bit, din_valid,
    input  din_ready, step_en, m_bit, ca, cb, ks_valid, tag_valid, phase, busy, done
  );

  modport slave (
    input  start, key_in, iv_in, ad_len, msg_len, din_bit, din_valid,
    output din_ready, step_en, m_bit, ca, cb, ks_valid, tag_valid, phase, busy, done
  );
endinterface

// File: rtl/acorn_phase_ctrl.sv
// Phase sequencer for the bit-serial ACORN-128 core: walks INIT, AD, padding,
// ENC and FINAL, and per cycle says whether the datapath steps and with which m/ca/cb.
module acorn_phase_ctrl #(
  parameter int LEN_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  acorn_phase_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_AD      = 3'd2,
    S_AD_PAD  = 3'd3,
    S_ENC     = 3'd4,
    S_ENC_PAD = 3'd5,
    S_FINAL   = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  localparam logic [10:0] INIT_LAST  = 11'd1791;
  localparam logic [10:0] IV_FIRST   = 11'd128;
  localparam logic [10:0] KEY_FLIP   = 11'd256;
  localparam logic [10:0] PAD_HALF   = 11'd128;
  localparam logic [10:0] PAD_LAST   = 11'd255;
  localparam logic [10:0] TAG_FIRST  = 11'd640;
  localparam logic [10:0] FINAL_LAST = 11'd767;

  state_t           state_q, state_d;
  logic [10:0]      cnt_q;
  logic [LEN_W-1:0] len_cnt_q;
  logic [127:0]     key_q;
  logic [127:0]     iv_q;
  logic [LEN_W-1:0] ad_len_q;
  logic [LEN_W-1:0] msg_len_q;

  logic             step_en;
  logic             m_bit;
  logic             ca;
  logic             cb;
  logic             din_ready;
  logic             ks_valid;
  logic             tag_valid;

  logic             start_accept;
  logic             data_phase;
  logic [LEN_W-1:0] data_len;
  logic             data_last;
  logic             state_change;

  assign start_accept = (state_q == S_IDLE) && bus.start;
  assign data_phase   = (state_q == S_AD) || (state_q == S_ENC);
  assign data_len     = (state_q == S_ENC) ? msg_len_q : ad_len_q;
  // Only meaningful inside AD/ENC, where the latched length is known nonzero.
  assign data_last    = (len_cnt_q == data_len - LEN_W'(1));
  assign state_change = (state_d != state_q);

  // Per-step outputs, decoded purely from registered state and counters
  // (plus the live handshake in the data phases).
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned; that is what keeps this block from inferring latches.
    step_en   = 1'b0;
    m_bit     = 1'b0;
    ca        = 1'b0;
    cb        = 1'b0;
    din_ready = 1'b0;
    ks_valid  = 1'b0;
    tag_valid = 1'b0;
    case (state_q)
      S_INIT: begin
        step_en = 1'b1;
        ca      = 1'b1;
        cb      = 1'b1;
        if (cnt_q < IV_FIRST)      m_bit = key_q[cnt_q[6:0]];
        else if (cnt_q < KEY_FLIP) m_bit = iv_q[cnt_q[6:0]];
        else if (cnt_q == KEY_FLIP) m_bit = ~key_q[0];
        else                        m_bit = key_q[cnt_q[6:0]];
      end
      S_AD: begin
        din_ready = 1'b1;
        step_en   = bus.din_valid;
        m_bit     = bus.din_bit;
        ca        = 1'b1;
        cb        = 1'b1;
      end
      S_AD_PAD: begin
        step_en = 1'b1;
        m_bit   = (cnt_q == 11'd0);
        ca      = (cnt_q < PAD_HALF);
        cb      = 1'b1;
      end
      S_ENC: begin
        din_ready = 1'b1;
        step_en   = bus.din_valid;
        m_bit     = bus.din_bit;
        ca        = 1'b1;
        cb        = 1'b0;
        ks_valid  = bus.din_valid;
      end
      S_ENC_PAD: begin
        step_en = 1'b1;
        m_bit   = (cnt_q == 11'd0);
        ca      = (cnt_q < PAD_HALF);
        cb      = 1'b0;
      end
      S_FINAL: begin
        step_en   = 1'b1;
        ca        = 1'b1;
        cb        = 1'b1;
        tag_valid = (cnt_q >= TAG_FIRST);
      end
      default: ;
    endcase
  end

  // Transitions fire on the edge that completes a phase's last step, so the
  // next phase starts with no bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.start) state_d = S_INIT;
      S_INIT:    if (cnt_q == INIT_LAST)
                   state_d = (ad_len_q != '0) ? S_AD : S_AD_PAD;
      S_AD:      if (step_en && data_last) state_d = S_AD_PAD;
      S_AD_PAD:  if (cnt_q == PAD_LAST)
                   state_d = (msg_len_q != '0) ? S_ENC : S_ENC_PAD;
      S_ENC:     if (step_en && data_last) state_d = S_ENC_PAD;
      S_ENC_PAD: if (cnt_q == PAD_LAST) state_d = S_FINAL;
      S_FINAL:   if (cnt_q == FINAL_LAST) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Counters restart on every phase entry and hold through handshake gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      len_cnt_q <= '0;
    end else if (state_change) begin
      cnt_q     <= '0;
      len_cnt_q <= '0;
    end else if (step_en) begin
      cnt_q <= cnt_q + 11'd1;
      if (data_phase) len_cnt_q <= len_cnt_q + LEN_W'(1);
    end
  end

  // Job parameters are captured once; a start seen while busy never reaches here.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q     <= '0;
      iv_q      <= '0;
      ad_len_q  <= '0;
      msg_len_q <= '0;
    end else if (start_accept) begin
      key_q     <= bus.key_in;
      iv_q      <= bus.iv_in;
      ad_len_q  <= bus.ad_len;
      msg_len_q <= bus.msg_len;
    end
  end

  assign bus.step_en   = step_en;
  assign bus.m_bit     = m_bit;
  assign bus.ca        = ca;
  assign bus.cb        = cb;
  assign bus.din_ready = din_ready;
  assign bus.ks_valid  = ks_valid;
  assign bus.tag_valid = tag_valid;
  assign bus.phase     = state_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);

  a_done_pulse: assert property (@(posedge clk) disable iff (rst)
    bus.done |=> !bus.done);

  a_step_when_busy: assert property (@(posedge clk) disable iff (rst)
    step_en |-> (state_q != S_IDLE));

  a_key_held: assert property (@(posedge clk) disable iff (rst)
    (state_q != S_IDLE) |=> $stable(key_q));

endmodule

// File: tb/tb_acorn_phase_ctrl.sv
// Scoreboard bench for acorn_phase_ctrl: a job-level reference model queues the
// expected step stream; a negedge monitor pops and compares on every step_en.
module tb_acorn_phase_ctrl;

  localparam int LEN_W = 16;

  typedef struct packed {
    logic [2:0] phase;
    logic       m;
    logic       ca;
    logic       cb;
    logic       ks;
    logic       tag;
  } step_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acorn_phase_ctrl_if #(.LEN_W(LEN_W)) bus();
  acorn_phase_ctrl #(.LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  step_t      exp_q[$];
  logic       din_q[$];
  logic [2:0] phase_log[$];

  int n_checks = 0;
  int n_errors = 0;
  int steps_seen = 0, ks_seen = 0, tag_seen = 0, init_ones = 0, gap_seen = 0;
  int base_steps, base_ks, base_tag, base_ones, base_gap, base_log;
  int cyc_cnt = 0;
  int vmode = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: the whole job as an ordered list of steps.
  task automatic push_model(input logic [127:0] key, input logic [127:0] iv,
                            input int a_len, input int m_len);
    logic d[$];
    logic m;
    for (int j = 0; j < a_len + m_len; j++) begin
      d.push_back(1'($urandom_range(0, 1)));
      din_q.push_back(d[j]);
    end
    for (int i = 0; i < 1792; i++) begin
      if (i < 128)       m = key[i];
      else if (i < 256)  m = iv[i-128];
      else if (i == 256) m = ~key[0];
      else               m = key[i%128];
      exp_q.push_back('{phase: 3'd1, m: m, ca: 1'b1, cb: 1'b1, ks: 1'b0, tag: 1'b0});
    end
    for (int j = 0; j < a_len; j++)
      exp_q.push_back('{phase: 3'd2, m: d[j], ca: 1'b1, cb: 1'b1, ks: 1'b0, tag: 1'b0});
    for (int j = 0; j < 256; j++)
      exp_q.push_back('{phase: 3'd3, m: (j == 0), ca: (j < 128), cb: 1'b1, ks: 1'b0, tag: 1'b0});
    for (int j = 0; j < m_len; j++)
      exp_q.push_back('{phase: 3'd4, m: d[a_len+j], ca: 1'b1, cb: 1'b0, ks: 1'b1, tag: 1'b0});
    for (int j = 0; j < 256; j++)
      exp_q.push_back('{phase: 3'd5, m: (j == 0), ca: (j < 128), cb: 1'b0, ks: 1'b0, tag: 1'b0});
    for (int j = 0; j < 768; j++)
      exp_q.push_back('{phase: 3'd6, m: 1'b0, ca: 1'b1, cb: 1'b1, ks: 1'b0, tag: (j >= 640)});
  endtask

  function automatic logic [31:0] seq_code(input int a_len, input int m_len);
    logic [31:0] c = 32'h1;
    if (a_len != 0) c = (c << 4) | 32'h2;
    c = (c << 4) | 32'h3;
    if (m_len != 0) c = (c << 4) | 32'h4;
    c = (c << 4) | 32'h5;
    c = (c << 4) | 32'h6;
    c = (c << 4) | 32'h7;
    c = (c << 4);
    return c;
  endfunction

  // Monitor / scoreboard consumer
  initial begin : monitor
    logic [2:0] last_phase;
    step_t act, exp;
    last_phase = 3'd0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (bus.phase != last_phase) begin
        phase_log.push_back(bus.phase);
        last_phase = bus.phase;
      end
      if ((bus.phase == 3'd2 || bus.phase == 3'd4) && !bus.din_valid) gap_seen++;
      if (bus.step_en) begin
        act = {bus.phase, bus.m_bit, bus.ca, bus.cb, bus.ks_valid, bus.tag_valid};
        if (exp_q.size() == 0) begin
          check("unexpected_step", bus.step_en, 1'b0);
        end else begin
          exp = exp_q.pop_front();
          check($sformatf("step_ph%0d_n%0d", exp.phase, steps_seen - base_steps),
                {bus.busy, act}, {1'b1, exp});
        end
        steps_seen++;
        if (bus.ks_valid) ks_seen++;
        if (bus.tag_valid) tag_seen++;
        if (bus.phase == 3'd1 && bus.m_bit) init_ones++;
      end else begin
        check("stall_flags", {bus.ks_valid, bus.tag_valid}, 2'b00);
      end
      if (bus.phase == 3'd0)
        check("idle_outputs", {bus.step_en, bus.m_bit, bus.ca, bus.cb, bus.din_ready,
                               bus.ks_valid, bus.tag_valid, bus.busy, bus.done}, 9'd0);
    end
  end

  // Serial data driver: presents the queue head, pops on an observed handshake.
  initial begin : driver
    logic hs;
    bus.din_valid = 1'b0;
    bus.din_bit   = 1'b0;
    forever begin
      @(negedge clk);
      hs = bus.din_ready && bus.din_valid;
      @(posedge clk);
      if (hs && din_q.size() > 0) void'(din_q.pop_front());
      #1;
      case (vmode)
        0:       bus.din_valid = 1'b1;
        1:       bus.din_valid = ~bus.din_valid;
        default: bus.din_valid = ($urandom_range(0, 3) != 0);
      endcase
      bus.din_bit = (din_q.size() > 0) ? din_q[0] : 1'b0;
    end
  end

  task automatic launch(input logic [127:0] key, input logic [127:0] iv,
                        input int a_len, input int m_len, output int c0);
    @(posedge clk); #1;
    bus.key_in  = key;
    bus.iv_in   = iv;
    bus.ad_len  = LEN_W'(a_len);
    bus.msg_len = LEN_W'(m_len);
    bus.start   = 1'b1;
    push_model(key, iv, a_len, m_len);
    base_steps = steps_seen;
    base_ks    = ks_seen;
    base_tag   = tag_seen;
    base_ones  = init_ones;
    base_gap   = gap_seen;
    base_log   = phase_log.size();
    @(posedge clk); #1;
    bus.start = 1'b0;
    c0 = cyc_cnt;
  endtask

  task automatic finish_job(input int a_len, input int m_len, input int c0);
    bit seen = 1'b0;
    int n = 3072 + a_len + m_len;
    logic [31:0] code = 32'h0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", seen, 1'b1);
    check("job_cycles", cyc_cnt - c0, n + (gap_seen - base_gap));
    check("phase_at_done", bus.phase, 3'd7);
    check("step_count", steps_seen - base_steps, n);
    check("ks_count", ks_seen - base_ks, m_len);
    check("tag_count", tag_seen - base_tag, 128);
    check("scoreboard_drained", exp_q.size(), 0);
    @(negedge clk);
    check("done_one_cycle", {bus.done, bus.busy, bus.phase}, 5'd0);
    @(posedge clk); #1;
    for (int i = base_log; i < phase_log.size(); i++) code = (code << 4) | 32'(phase_log[i]);
    check("phase_seq", code, seq_code(a_len, m_len));
    exp_q.delete();
    din_q.delete();
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c0;
    logic [127:0] k1, iv1, k2;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.key_in  = '0;
    bus.iv_in   = '0;
    bus.ad_len  = '0;
    bus.msg_len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {bus.phase, bus.busy, bus.done, bus.step_en, bus.m_bit, bus.ca,
                            bus.cb, bus.din_ready, bus.ks_valid, bus.tag_valid}, 12'd0);
    @(posedge clk); #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Empty job
    vmode = 0;
    launch('0, '0, 0, 0, c0);
    finish_job(0, 0, c0);

    // Init bit mapping
    launch(128'h1, 128'h80000000_00000000_00000000_00000000, 0, 0, c0);
    finish_job(0, 0, c0);
    check("init_ones", init_ones - base_ones, 13);

    // AD with stalls
    vmode = 1;
    launch({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 8, 0, c0);
    finish_job(8, 0, c0);
    check("ad_gaps_present", (gap_seen - base_gap) > 0, 1'b1);

    // Encryption
    vmode = 0;
    launch({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0, 24, c0);
    finish_job(0, 24, c0);

    // Random jobs with random valid gaps
    vmode = 2;
    for (int t = 0; t < 3; t++) begin
      int a = $urandom_range(0, 40);
      int m = $urandom_range(0, 40);
      launch({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, a, m, c0);
      finish_job(a, m, c0);
    end

    // Start while busy (during AD_PAD) is ignored
    vmode = 0;
    k1  = {$urandom, $urandom, $urandom, $urandom};
    iv1 = {$urandom, $urandom, $urandom, $urandom};
    launch(k1, iv1, 5, 3, c0);
    for (int k = 0; k < 5000; k++) begin
      @(posedge clk); #1;
      if (bus.phase == 3'd3) break;
    end
    bus.key_in  = ~k1;
    bus.ad_len  = LEN_W'(7);
    bus.msg_len = LEN_W'(9);
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    finish_job(5, 3, c0);
    check("latched_key_kept", dut.key_q, k1);
    check("latched_ad_len_kept", dut.ad_len_q, LEN_W'(5));

    // Reset at INIT step 1000, then restart with a new key
    vmode = 2;
    launch(~k1, iv1, 3, 2, c0);
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      if (steps_seen - base_steps >= 1000) break;
    end
    rst = 1'b1;
    @(negedge clk);
    check("pre_reset_phase", bus.phase, 3'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    din_q.delete();
    @(negedge clk);
    check("midjob_reset_outputs", {bus.phase, bus.busy, bus.done, bus.step_en, bus.m_bit, bus.ca,
                                   bus.cb, bus.din_ready, bus.ks_valid, bus.tag_valid}, 12'd0);
    check("reset_clears_key", dut.key_q, 128'd0);
    k2 = {$urandom, $urandom, $urandom, $urandom};
    launch(k2, ~iv1, 2, 4, c0);
    finish_job(2, 4, c0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/acorn_phase_ctrl.md
# acorn_phase_ctrl

Phase sequencer for the bit-serial ACORN-128 core. It owns the whole encryption flow: initialization (1792 steps), associated-data absorb plus padding, plaintext encryption plus padding, and finalization (768 steps). Each cycle it decides whether the state-update datapath advances one step, and supplies that step's message bit `m_bit` and control bits `ca` and `cb`. It sits between the host-side key/IV/data interfaces and the `state_update128` datapath, replacing the free-running counter used by the standalone initializer.

## Interface

Parameters:
- `LEN_W`, default 16, width of the AD and message bit-length inputs.

Ports:
- `clk`, input, 1, the single clock.
- `rst`, input, 1, reset: synchronous, active-high.
- `start`, input, 1, begin a job. Sampled only in IDLE.
- `key_in`, input, 128, key; latched on an accepted `start`.
- `iv_in`, input, 128, IV; latched on an accepted `start`.
- `ad_len`, input, LEN_W, AD length in bits; latched on an accepted `start`.
- `msg_len`, input, LEN_W, plaintext length in bits; latched on an accepted `start`.
- `din_bit`, input, 1, serial AD or plaintext bit.
- `din_valid`, input, 1, `din_bit` is valid.
- `din_ready`, output, 1, controller accepts `din_bit` this cycle.
- `step_en`, output, 1, datapath performs one state update this cycle.
- `m_bit`, output, 1, message bit for this step.
- `ca`, output, 1, control bit a for this step.
- `cb`, output, 1, control bit b for this step.
- `ks_valid`, output, 1, this step's keystream bit is a ciphertext bit (ENC phase).
- `tag_valid`, output, 1, this step's keystream bit is a tag bit.
- `phase`, output, 3, current state encoding.
- `busy`, output, 1, high in every state except IDLE.
- `done`, output, 1, one-cycle pulse when the job completes.

## Operation

- States and `phase` encoding: IDLE=0, INIT=1, AD=2, AD_PAD=3, ENC=4, ENC_PAD=5, FINAL=6, DONE=7.
- A single step counter `cnt` is 11 bits. It clears on every state entry and increments on each cycle where `step_en` is high.
- **IDLE**
  - On `start`, latch `key_in`, `iv_in`, `ad_len` and `msg_len`, then go to INIT.
- **INIT**
  - `step_en`=1 every cycle; `ca`=`cb`=1.
  - `m_bit` by step index i:
    - i=0..127: `key[i]`
    - i=128..255: `iv[i-128]`
    - i=256: `key[0]^1`
    - i=257..1791: `key[i mod 128]`
  - After step 1791, go to AD if `ad_len`≠0, else go to AD_PAD.
- **AD**
  - `din_ready`=1.
  - `step_en` = `din_valid`; `m_bit` = `din_bit`; `ca`=`cb`=1.
  - After `ad_len` accepted bits, go to AD_PAD.
- **AD_PAD**
  - 256 steps, one per cycle.
  - `m_bit`=1 at step 0, otherwise 0.
  - `ca`=1 for steps 0..127, `ca`=0 for steps 128..255; `cb`=1 throughout.
  - Then go to ENC if `msg_len`≠0, else go to ENC_PAD.
- **ENC**
  - Same handshake as AD; `ca`=1, `cb`=0.
  - `ks_valid` = `step_en`.
  - After `msg_len` bits, go to ENC_PAD.
- **ENC_PAD**
  - Same as AD_PAD, except `cb`=0 throughout.
  - Then go to FINAL.
- **FINAL**
  - 768 steps; `m_bit`=0; `ca`=`cb`=1.
  - `tag_valid`=1 on steps 640..767.
  - Then go to DONE.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
- Outside INIT, AD, AD_PAD, ENC, ENC_PAD and FINAL, these outputs are all 0: `step_en`, `m_bit`, `ca`, `cb`, `din_ready`, `ks_valid`, `tag_valid`.
- Data-phase bit counting uses a separate LEN_W-bit counter. The data-phase exit compare is against the latched length, never against live inputs.

## Timing

- Reset: on the first rising edge with `rst`=1, the controller enters IDLE and clears `cnt`, the length counter and the latched registers.
  - All outputs are 0 the following cycle, including `phase`=0 and `busy`=0.
  - `rst` takes priority over every other event, including reset mid-job.
- Outputs are combinational from registered state and counters. `din_ready` has no dependency on `din_valid`.
- `start` is sampled at edge E0. INIT step 0 occurs in the cycle after E0.
- With both lengths 0, the job is exactly 3072 steps (1792+256+256+768) on consecutive cycles, with no bubbles. `done` asserts in the cycle after FINAL step 767.
- With lengths A and M, total steps = 3072+A+M. The cycle count is 3072+A+M plus the cycles in which `din_valid` was low during AD or ENC.
- `start` while `busy` is ignored; latched values are unchanged.
- A `din_valid` gap stalls the step. `cnt`, the length counter and the datapath state hold.
- Phase transitions occur on the edge of the last step, so there is no idle cycle between phases.

## Test plan

- **Empty job:** `key`=`iv`=0, `ad_len`=`msg_len`=0, `start` pulse → exactly 3072 `step_en` cycles, then `done` one cycle later. `phase` sequence is 1,3,5,6,7,0. Exactly 128 `tag_valid` cycles. Zero `ks_valid` cycles.
- **Init bit mapping:** `key`=128'h1, `iv`=128'h80000000_00000000_00000000_00000000 → `m_bit`=1 at INIT steps 0 and 255. `m_bit`=0 at step 256. `m_bit`=1 at steps 384, 512, …, 1664. All other INIT steps have `m_bit`=0.
- **AD with stalls:** `ad_len`=8, `msg_len`=0, `din_valid` toggling every other cycle → 8 AD steps over 16 cycles, `m_bit` mirrors `din_bit`, and `cnt` holds during gaps. AD_PAD shows `ca` falling after 128 steps.
- **Encryption:** `ad_len`=0, `msg_len`=24, `din_valid` constant 1 → 24 `ks_valid` cycles with `ca`=1 and `cb`=0. ENC_PAD shows `cb`=0 and `m_bit`=1 only at step 0. Total 3096 steps.
- **Reset mid-INIT:** assert `rst` at INIT step 1000 → IDLE on the next edge with all outputs 0. A new `start` restarts from INIT step 0 with the new key.
- **Start while busy:** pulse `start` with a different key during AD_PAD → ignored. FINAL completes and the latched key is unchanged.
